// File: rtl/compare_stream_tracker.sv
// Compares each accepted sample with the previous one and accumulates max/min/gt/lt/eq over a fixed window.
// Latency: per-sample compare code 1 cycle after accept; window results 1 cycle after the last accept. Backpressure: oReady low only in the single DONE cycle.
module compare_stream_tracker #(
    parameter int DATA_W = 8,
    parameter int WINDOW = 16,
    parameter int CNT_W  = 5
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iClear,
    input  logic [DATA_W-1:0] iData,
    input  logic              iValid,
    output logic              oReady,
    output logic [2:0]        oCmp,
    output logic              oCmpValid,
    output logic [DATA_W-1:0] oMax,
    output logic [DATA_W-1:0] oMin,
    output logic [CNT_W-1:0]  oCntGt,
    output logic [CNT_W-1:0]  oCntLt,
    output logic [CNT_W-1:0]  oCntEq,
    output logic              oDone
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_LT = 3'b010;
    localparam logic [2:0] CMP_EQ = 3'b001;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d, wmax_q, wmax_d, wmin_q, wmin_d;
    logic [CNT_W-1:0]  idx_q, idx_d, gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
    logic [2:0]        cmp_q, cmp_d;
    logic              cmp_vld_q, cmp_vld_d, done_q, done_d;
    logic [DATA_W-1:0] rmax_q, rmax_d, rmin_q, rmin_d;
    logic [CNT_W-1:0]  rgt_q, rgt_d, rlt_q, rlt_d, req_q, req_d;

    logic              accept, is_gt, is_lt;
    logic [DATA_W-1:0] nmax, nmin;
    logic [CNT_W-1:0]  ngt, nlt, neq;

    assign oReady = (state_q != S_DONE);
    assign accept = iValid && oReady;
    assign is_gt  = iData > prev_q;
    assign is_lt  = iData < prev_q;
    assign nmax   = (iData > wmax_q) ? iData : wmax_q;
    assign nmin   = (iData < wmin_q) ? iData : wmin_q;
    assign ngt    = is_gt ? gt_q + CNT_ONE : gt_q;
    assign nlt    = is_lt ? lt_q + CNT_ONE : lt_q;
    assign neq    = (!is_gt && !is_lt) ? eq_q + CNT_ONE : eq_q;

    always_comb begin
        state_d   = state_q;
        prev_d    = prev_q;
        wmax_d    = wmax_q;
        wmin_d    = wmin_q;
        idx_d     = idx_q;
        gt_d      = gt_q;
        lt_d      = lt_q;
        eq_d      = eq_q;
        cmp_d     = cmp_q;
        cmp_vld_d = 1'b0;
        done_d    = 1'b0;
        rmax_d    = rmax_q;
        rmin_d    = rmin_q;
        rgt_d     = rgt_q;
        rlt_d     = rlt_q;
        req_d     = req_q;

        // Abort drops the partial window; published results stay visible.
        if (iClear) begin
            state_d = S_EMPTY;
            prev_d  = '0;
            wmax_d  = '0;
            wmin_d  = '0;
            idx_d   = '0;
            gt_d    = '0;
            lt_d    = '0;
            eq_d    = '0;
            cmp_d   = CMP_EQ;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        prev_d  = iData;
                        wmax_d  = iData;
                        wmin_d  = iData;
                        idx_d   = CNT_ONE;
                        cmp_d   = CMP_EQ;
                        state_d = S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (accept) begin
                        cmp_d     = is_gt ? CMP_GT : (is_lt ? CMP_LT : CMP_EQ);
                        cmp_vld_d = 1'b1;
                        prev_d    = iData;
                        wmax_d    = nmax;
                        wmin_d    = nmin;
                        gt_d      = ngt;
                        lt_d      = nlt;
                        eq_d      = neq;
                        idx_d     = idx_q + CNT_ONE;
                        if (idx_q == LAST_IDX) begin
                            rmax_d  = nmax;
                            rmin_d  = nmin;
                            rgt_d   = ngt;
                            rlt_d   = nlt;
                            req_d   = neq;
                            done_d  = 1'b1;
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    prev_d  = '0;
                    wmax_d  = '0;
                    wmin_d  = '0;
                    idx_d   = '0;
                    gt_d    = '0;
                    lt_d    = '0;
                    eq_d    = '0;
                    state_d = S_EMPTY;
                end
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q   <= S_EMPTY;
            prev_q    <= '0;
            wmax_q    <= '0;
            wmin_q    <= '0;
            idx_q     <= '0;
            gt_q      <= '0;
            lt_q      <= '0;
            eq_q      <= '0;
            cmp_q     <= CMP_EQ;
            cmp_vld_q <= 1'b0;
            done_q    <= 1'b0;
            rmax_q    <= '0;
            rmin_q    <= '0;
            rgt_q     <= '0;
            rlt_q     <= '0;
            req_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            wmax_q    <= wmax_d;
            wmin_q    <= wmin_d;
            idx_q     <= idx_d;
            gt_q      <= gt_d;
            lt_q      <= lt_d;
            eq_q      <= eq_d;
            cmp_q     <= cmp_d;
            cmp_vld_q <= cmp_vld_d;
            done_q    <= done_d;
            rmax_q    <= rmax_d;
            rmin_q    <= rmin_d;
            rgt_q     <= rgt_d;
            rlt_q     <= rlt_d;
            req_q     <= req_d;
        end
    end

    assign oCmp      = cmp_q;
    assign oCmpValid = cmp_vld_q;
    assign oDone     = done_q;
    assign oMax      = rmax_q;
    assign oMin      = rmin_q;
    assign oCntGt    = rgt_q;
    assign oCntLt    = rlt_q;
    assign oCntEq    = req_q;

endmodule

// File: tb/tb_compare_stream_tracker.sv
// Directed bench for compare_stream_tracker: a WINDOW=4 instance for the handshake/clear/extreme cases
// and a WINDOW=16 instance for a scoreboarded multi-window run and an asynchronous reset mid-window.
module tb_compare_stream_tracker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       a_clear, a_valid, a_ready, a_cmp_vld, a_done;
    logic [7:0] a_data, a_max, a_min;
    logic [2:0] a_cmp, a_gt, a_lt, a_eq;

    logic       b_clear, b_valid, b_ready, b_cmp_vld, b_done;
    logic [7:0] b_data, b_max, b_min;
    logic [2:0] b_cmp;
    logic [4:0] b_gt, b_lt, b_eq;

    int n_checks = 0;
    int n_errors = 0;

    compare_stream_tracker #(.DATA_W(8), .WINDOW(4), .CNT_W(3)) u_dut_a (
        .iClk(clk), .iRst_n(rst_n), .iClear(a_clear), .iData(a_data), .iValid(a_valid),
        .oReady(a_ready), .oCmp(a_cmp), .oCmpValid(a_cmp_vld), .oMax(a_max), .oMin(a_min),
        .oCntGt(a_gt), .oCntLt(a_lt), .oCntEq(a_eq), .oDone(a_done)
    );

    compare_stream_tracker #(.DATA_W(8), .WINDOW(16), .CNT_W(5)) u_dut_b (
        .iClk(clk), .iRst_n(rst_n), .iClear(b_clear), .iData(b_data), .iValid(b_valid),
        .oReady(b_ready), .oCmp(b_cmp), .oCmpValid(b_cmp_vld), .oMax(b_max), .oMin(b_min),
        .oCntGt(b_gt), .oCntLt(b_lt), .oCntEq(b_eq), .oDone(b_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic v, input logic [7:0] d, input logic c);
        a_valid = v;
        a_data  = d;
        a_clear = c;
    endtask

    task automatic check_a_cmp(input string tag, input logic [2:0] cmp, input logic vld);
        check({tag, ".cmp"}, 32'(a_cmp), 32'(cmp));
        check({tag, ".vld"}, 32'(a_cmp_vld), 32'(vld));
    endtask

    task automatic check_a_res(input string tag, input logic [7:0] mx, input logic [7:0] mn,
                               input logic [2:0] g, input logic [2:0] l, input logic [2:0] e);
        check({tag, ".max"}, 32'(a_max), 32'(mx));
        check({tag, ".min"}, 32'(a_min), 32'(mn));
        check({tag, ".gt"},  32'(a_gt),  32'(g));
        check({tag, ".lt"},  32'(a_lt),  32'(l));
        check({tag, ".eq"},  32'(a_eq),  32'(e));
    endtask

    initial begin
        logic [7:0] d, prev, mx, mn;
        logic [4:0] g, l, e;
        logic [2:0] ecmp;

        rst_n = 1'b0;
        drive_a(1'b0, 8'h00, 1'b0);
        b_valid = 1'b0; b_data = 8'h00; b_clear = 1'b0;
        prev = 8'h00; mx = 8'h00; mn = 8'h00; g = '0; l = '0; e = '0;

        #7;
        check_a_cmp("rst", 3'b001, 1'b0);
        check("rst.done",  32'(a_done), 32'(0));
        check("rst.ready", 32'(a_ready), 32'(1));
        check_a_res("rst", 8'h00, 8'h00, 3'd0, 3'd0, 3'd0);
        #5 rst_n = 1'b1;
        step;

        // T1 basic window 5,9,9,2
        drive_a(1'b1, 8'd5, 1'b0); step; check_a_cmp("t1.s0", 3'b001, 1'b0);
        drive_a(1'b1, 8'd9, 1'b0); step; check_a_cmp("t1.s1", 3'b100, 1'b1);
        drive_a(1'b1, 8'd9, 1'b0); step; check_a_cmp("t1.s2", 3'b001, 1'b1);
        check("t1.done_early", 32'(a_done), 32'(0));
        drive_a(1'b1, 8'd2, 1'b0); step; check_a_cmp("t1.s3", 3'b010, 1'b1);
        check("t1.done",  32'(a_done), 32'(1));
        check("t1.ready", 32'(a_ready), 32'(0));
        check_a_res("t1", 8'd9, 8'd2, 3'd1, 3'd1, 3'd1);

        // T2 7 held through DONE is taken afterwards as a first sample
        drive_a(1'b1, 8'd7, 1'b0); step;
        check("t2.done_off", 32'(a_done), 32'(0));
        check("t2.vld_off",  32'(a_cmp_vld), 32'(0));
        check("t2.ready",    32'(a_ready), 32'(1));
        step; check_a_cmp("t2.first", 3'b001, 1'b0);
        drive_a(1'b1, 8'd8, 1'b0); step; check_a_cmp("t2.next", 3'b100, 1'b1);

        // T3 clear aborts windows, results of previous window held
        drive_a(1'b0, 8'd0, 1'b1); step; check_a_cmp("t3.clr0", 3'b001, 1'b0);
        check_a_res("t3.held0", 8'd9, 8'd2, 3'd1, 3'd1, 3'd1);
        drive_a(1'b1, 8'd3, 1'b0); step; check_a_cmp("t3.s0", 3'b001, 1'b0);
        drive_a(1'b1, 8'd8, 1'b0); step; check_a_cmp("t3.s1", 3'b100, 1'b1);
        drive_a(1'b1, 8'd99, 1'b1); step; check_a_cmp("t3.clr1", 3'b001, 1'b0);
        check("t3.clr.done",  32'(a_done), 32'(0));
        check("t3.clr.ready", 32'(a_ready), 32'(1));
        drive_a(1'b1, 8'd1, 1'b0); step; check_a_cmp("t3.r0", 3'b001, 1'b0);
        step; check_a_cmp("t3.r1", 3'b001, 1'b1);
        step; check_a_cmp("t3.r2", 3'b001, 1'b1);
        check_a_res("t3.held1", 8'd9, 8'd2, 3'd1, 3'd1, 3'd1);
        step; check("t3.done", 32'(a_done), 32'(1));
        check_a_res("t3", 8'd1, 8'd1, 3'd0, 3'd0, 3'd3);

        // T4 unsigned extremes
        drive_a(1'b0, 8'd0, 1'b0); step; check("t4.idle.done", 32'(a_done), 32'(0));
        drive_a(1'b1, 8'h00, 1'b0); step; check_a_cmp("t4.s0", 3'b001, 1'b0);
        drive_a(1'b1, 8'hFF, 1'b0); step; check_a_cmp("t4.s1", 3'b100, 1'b1);
        drive_a(1'b1, 8'h80, 1'b0); step; check_a_cmp("t4.s2", 3'b010, 1'b1);
        drive_a(1'b1, 8'hFF, 1'b0); step; check_a_cmp("t4.s3", 3'b100, 1'b1);
        check("t4.done", 32'(a_done), 32'(1));
        check_a_res("t4", 8'hFF, 8'h00, 3'd2, 3'd1, 3'd0);
        drive_a(1'b0, 8'd0, 1'b0);

        // T6 three scoreboarded windows of random data, WINDOW=16
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 16; k++) begin
                d = (w == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
                b_valid = 1'b1;
                b_data  = d;
                step;
                if (k == 0) begin
                    mx = d; mn = d; g = '0; l = '0; e = '0;
                    ecmp = 3'b001;
                end else begin
                    if (d > prev) begin ecmp = 3'b100; g = g + 5'd1; end
                    else if (d < prev) begin ecmp = 3'b010; l = l + 5'd1; end
                    else begin ecmp = 3'b001; e = e + 5'd1; end
                    if (d > mx) mx = d;
                    if (d < mn) mn = d;
                end
                prev = d;
                check("t6.cmp",  32'(b_cmp), 32'(ecmp));
                check("t6.vld",  32'(b_cmp_vld), 32'(k != 0));
                check("t6.done", 32'(b_done), 32'(k == 15));
                if (k == 15) begin
                    check("t6.max", 32'(b_max), 32'(mx));
                    check("t6.min", 32'(b_min), 32'(mn));
                    check("t6.gt",  32'(b_gt),  32'(g));
                    check("t6.lt",  32'(b_lt),  32'(l));
                    check("t6.eq",  32'(b_eq),  32'(e));
                end
            end
            b_valid = 1'b0;
            step;
            check("t6.gap.done",  32'(b_done), 32'(0));
            check("t6.gap.ready", 32'(b_ready), 32'(1));
        end

        // T5 asynchronous reset mid-window
        b_valid = 1'b1;
        b_data = 8'd10; step;
        b_data = 8'd20; step;
        b_data = 8'd30; step;
        check("t5.pre.cmp", 32'(b_cmp), 32'(3'b100));
        b_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        check("t5.cmp",   32'(b_cmp), 32'(3'b001));
        check("t5.vld",   32'(b_cmp_vld), 32'(0));
        check("t5.max",   32'(b_max), 32'(0));
        check("t5.gt",    32'(b_gt), 32'(0));
        check("t5.done",  32'(b_done), 32'(0));
        check("t5.ready", 32'(b_ready), 32'(1));
        check("t5.a.max", 32'(a_max), 32'(0));
        #2 rst_n = 1'b1;
        b_valid = 1'b1;
        b_data = 8'd50; step;
        check("t5.first.cmp", 32'(b_cmp), 32'(3'b001));
        check("t5.first.vld", 32'(b_cmp_vld), 32'(0));
        b_data = 8'd40; step;
        check("t5.second.cmp", 32'(b_cmp), 32'(3'b010));
        check("t5.second.vld", 32'(b_cmp_vld), 32'(1));
        b_valid = 1'b0;
        step;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
